alu_cmd_issue: RTL and testbench

//  Producer side of the ALU command interface. Decodes one instruction per handshake into
//  {cmd, in1, in2, rd} and holds it in a registered issue stage that feeds the ALU directly.

---
 rtl/alu_cmd_issue.sv | 110 +++++++++++
 tb/tb_alu_cmd_issue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - one-entry registered issue stage decoding instructions into ALU commands
module alu_cmd_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       cmd,
    output logic [31:0]      in1,
    output logic [31:0]      in2,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic        state;
    logic        in_fire;
    logic        out_fire;
    logic [5:0]  opcode;
    logic [15:0] imm;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] shamt_imm;
    logic        dec_legal;
    logic [3:0]  dec_cmd;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic        unused_instr_bits;

    assign opcode    = instr[31:26];
    assign imm       = instr[15:0];
    assign sext_imm  = {{16{imm[15]}}, imm};
    assign zext_imm  = {16'b0, imm};
    assign shamt_imm = {27'b0, imm[4:0]};
    assign unused_instr_bits = ^instr[20:16];

    assign out_valid = (state == FULL);
    assign in_ready  = ~out_valid | out_ready;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Operands default to rs1/rs2; only the exceptions in the table override them.
    always_comb begin
        dec_legal = 1'b1;
        dec_cmd   = 4'b0000;
        dec_in1   = rs1_val;
        dec_in2   = rs2_val;
        case (opcode)
            6'h00: dec_cmd = 4'b0000;
            6'h01: dec_cmd = 4'b0010;
            6'h02: dec_cmd = 4'b0100;
            6'h03: dec_cmd = 4'b0101;
            6'h04: dec_cmd = 4'b0110;
            6'h05: dec_cmd = 4'b0111;
            6'h06: dec_cmd = 4'b1000;
            6'h07: dec_cmd = 4'b1001;
            6'h08: dec_cmd = 4'b1010;
            6'h09: dec_cmd = 4'b1100;
            6'h0A: dec_cmd = 4'b1101;
            6'h20: begin dec_cmd = 4'b0000; dec_in2 = sext_imm; end
            6'h21: begin dec_cmd = 4'b0010; dec_in2 = sext_imm; end
            6'h22: begin dec_cmd = 4'b0100; dec_in2 = zext_imm; end
            6'h23: begin dec_cmd = 4'b0101; dec_in2 = zext_imm; end
            6'h26: begin dec_cmd = 4'b1000; dec_in2 = shamt_imm; end
            6'h27: begin dec_cmd = 4'b1001; dec_in2 = shamt_imm; end
            6'h28: begin dec_cmd = 4'b1010; dec_in2 = shamt_imm; end
            6'h29: begin dec_cmd = 4'b1100; dec_in2 = {imm, 16'b0}; end
            6'h30: begin dec_cmd = 4'b0010; dec_in1 = 32'b0; dec_in2 = rs1_val; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal ops are consumed but never loaded, so the held command is untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            cmd       <= '0;
            in1       <= '0;
            in2       <= '0;
            rd        <= '0;
            illegal   <= 1'b0;
            issue_cnt <= '0;
        end else begin
            if (out_fire) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            illegal <= in_fire & ~dec_legal & ~flush;
            if (flush) begin
                state <= EMPTY;
            end else if (in_fire && dec_legal) begin
                state <= FULL;
                cmd   <= dec_cmd;
                in1   <= dec_in1;
                in2   <= dec_in2;
                rd    <= instr[25:21];
            end else if (out_fire) begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - randomized and directed checks of alu_cmd_issue against a behavioural model
module tb_alu_cmd_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  cmd;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] issue_cnt;

    alu_cmd_issue #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid),
        .out_ready(out_ready), .cmd(cmd), .in1(in1), .in2(in2), .rd(rd),
        .illegal(illegal), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state: what the ALU must currently see.
    bit          m_valid = 1'b0;
    logic [3:0]  m_cmd = '0;
    logic [31:0] m_in1 = '0;
    logic [31:0] m_in2 = '0;
    logic [4:0]  m_rd = '0;
    bit          m_ill = 1'b0;
    int          m_cnt = 0;

    logic [5:0] legal_ops [19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h08, 6'h09, 6'h0A, 6'h20, 6'h21, 6'h22, 6'h23, 6'h26,
                                   6'h27, 6'h28, 6'h29};
    logic [3:0] reg_cmds [11] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                              output bit leg, output logic [3:0] c,
                              output logic [31:0] x, output logic [31:0] y);
        int op;
        int im;
        op  = int'(ins[31:26]);
        im  = int'(ins[15:0]);
        leg = 1'b1;
        x   = a;
        y   = b;
        c   = 4'd0;
        if (op <= 10) begin
            c = reg_cmds[op];
        end else begin
            case (op)
                32: begin c = 4'd0;  y = (im >= 32768) ? 32'(im - 65536) : 32'(im); end
                33: begin c = 4'd2;  y = (im >= 32768) ? 32'(im - 65536) : 32'(im); end
                34: begin c = 4'd4;  y = 32'(im); end
                35: begin c = 4'd5;  y = 32'(im); end
                38: begin c = 4'd8;  y = 32'(im % 32); end
                39: begin c = 4'd9;  y = 32'(im % 32); end
                40: begin c = 4'd10; y = 32'(im % 32); end
                41: begin c = 4'd12; y = 32'(im * 65536); end
                48: begin c = 4'd2;  x = 32'd0; y = a; end
                default: leg = 1'b0;
            endcase
        end
    endtask

    always @(posedge clk) begin
        bit          rdy;
        bit          ofire;
        bit          ifire;
        bit          leg;
        logic [3:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        if (rst) begin
            m_valid = 1'b0; m_cmd = '0; m_in1 = '0; m_in2 = '0; m_rd = '0;
            m_ill = 1'b0; m_cnt = 0;
        end else begin
            rdy   = !m_valid || out_ready;
            ofire = m_valid && out_ready;
            ifire = in_valid && rdy;
            ref_decode(instr, rs1_val, rs2_val, leg, c, x, y);
            if (ofire) m_cnt = (m_cnt + 1) % 65536;
            m_ill = ifire && !leg && !flush;
            if (ofire) m_valid = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
            end else if (ifire && leg) begin
                m_valid = 1'b1;
                m_cmd = c; m_in1 = x; m_in2 = y; m_rd = instr[25:21];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
            if (m_valid) begin
                chk("cmd", 32'(cmd), 32'(m_cmd));
                chk("in1", in1, m_in1);
                chk("in2", in2, m_in2);
                chk("rd", 32'(rd), 32'(m_rd));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] r, input logic [15:0] im);
        return {op, r, 5'd0, im};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b1; instr = mk(6'h00, 5'd1, 16'h0);
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_in1", in1, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);

        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        instr = mk(6'h20, 5'd3, 16'hFFFF); rs1_val = 32'd5; rs2_val = 32'd77;
        cyc();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_cmd", 32'(cmd), 32'd0);
        chk("addi_in1", in1, 32'd5);
        chk("addi_in2", in2, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd), 32'd3);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("addi_cnt", 32'(issue_cnt), 32'd1);

        out_ready = 1'b0; in_valid = 1'b1;
        instr = mk(6'h01, 5'd4, 16'h0); rs1_val = 32'd100; rs2_val = 32'd30;
        cyc();
        instr = mk(6'h05, 5'd6, 16'h0); rs1_val = 32'hF0F0; rs2_val = 32'h0FF0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_sub_cmd", 32'(cmd), 32'd2);
            chk("bp_sub_in1", in1, 32'd100);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_xor_cmd", 32'(cmd), 32'd7);
        chk("bp_xor_rd", 32'(rd), 32'd6);
        chk("bp_cnt_sub", 32'(issue_cnt), 32'd2);
        in_valid = 1'b0;
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_cnt_xor", 32'(issue_cnt), 32'd3);

        in_valid = 1'b1; instr = mk(6'h3F, 5'd2, 16'h1234);
        cyc();
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        cyc();
        chk("ill_clear", 32'(illegal), 32'd0);

        in_valid = 1'b1; out_ready = 1'b0; instr = mk(6'h30, 5'd9, 16'h0); rs1_val = 32'd12;
        cyc();
        chk("neg_in1", in1, 32'd0);
        chk("neg_in2", in2, 32'd12);
        flush = 1'b1; instr = mk(6'h29, 5'd8, 16'hABCD);
        cyc();
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush_lui_dropped", 32'(out_valid), 32'd0);
        chk("flush_cnt", 32'(issue_cnt), 32'd3);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            if ($urandom_range(0, 9) < 8)
                instr = {legal_ops[$urandom_range(0, 18)], 26'($urandom)};
            else
                instr = $urandom;
            if ($urandom_range(0, 9) == 0) instr[31:26] = 6'h30;
            cyc();
        end

        flush = 1'b0; in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; instr = mk(6'h00, 5'd1, 16'h0);
        for (int i = 0; i < 70000 && m_cnt != 65535; i++) cyc();
        chk("wrap_reached", 32'(m_cnt), 32'd65535);
        in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        chk("wrap_pre", 32'(issue_cnt), 32'h0000_FFFF);
        out_ready = 1'b1;
        cyc();
        chk("wrap_zero", 32'(issue_cnt), 32'd0);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
